// File: rtl/seq_ctrl_if.sv
// Bundles the sequencer's control inputs, fetch/execute results and status outputs.
// The slave modport is the sequencer side; the master modport is the driver side.
interface seq_ctrl_if;
  logic        start;
  logic        step_mode;
  logic        step;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic        dmem_error;
  logic        cnd;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] valM;
  logic [63:0] PC;
  logic [5:0]  stage_en;
  logic [2:0]  stat;
  logic        retire;
  logic [31:0] instr_count;

  modport slave (
    input  start, step_mode, step, icode, instr_valid, imem_error, dmem_error, cnd,
    input  valC, valP, valM,
    output PC, stage_en, stat, retire, instr_count
  );

  modport master (
    output start, step_mode, step, icode, instr_valid, imem_error, dmem_error, cnd,
    output valC, valP, valM,
    input  PC, stage_en, stat, retire, instr_count
  );
endinterface

// File: rtl/seq_ctrl.sv
// Sequential (non-pipelined) instruction controller: walks one instruction through six
// one-cycle stages, selects the next PC, and parks in STOP on halt or address/instruction faults.
module seq_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter logic [3:0]  HALT_ICODE = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  seq_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_PAUSE,
    S_STOP
  } state_t;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  localparam logic [3:0] IC_JXX  = 4'h7;
  localparam logic [3:0] IC_CALL = 4'h8;
  localparam logic [3:0] IC_RET  = 4'h9;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  w_stage_en;
  logic        w_stop_load;
  logic [2:0]  w_stop_code;
  logic [63:0] w_pc_next;
  logic [63:0] r_pc;
  logic [2:0]  r_stat;
  logic        r_cnd;
  logic [31:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_stage_en  = 6'b000000;
    w_stop_load = 1'b0;
    w_stop_code = ST_AOK;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_stage_en = 6'b000001;
        // Fault priority: bad fetch address, then illegal instruction, then halt.
        if (bus.imem_error) begin
          w_stop_load = 1'b1;
          w_stop_code = ST_ADR;
        end else if (!bus.instr_valid) begin
          w_stop_load = 1'b1;
          w_stop_code = ST_INS;
        end else if (bus.icode == HALT_ICODE) begin
          w_stop_load = 1'b1;
          w_stop_code = ST_HLT;
        end
        w_next = w_stop_load ? S_STOP : S_DECODE;
      end
      S_DECODE: begin
        w_stage_en = 6'b000010;
        w_next     = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_stage_en = 6'b000100;
        w_next     = S_MEMORY;
      end
      S_MEMORY: begin
        w_stage_en = 6'b001000;
        if (bus.dmem_error) begin
          w_stop_load = 1'b1;
          w_stop_code = ST_ADR;
          w_next      = S_STOP;
        end else begin
          w_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        w_stage_en = 6'b010000;
        w_next     = S_PCUPD;
      end
      S_PCUPD: begin
        w_stage_en = 6'b100000;
        w_next     = bus.step_mode ? S_PAUSE : S_FETCH;
      end
      S_PAUSE: begin
        if (bus.step || !bus.step_mode) w_next = S_FETCH;
      end
      S_STOP: begin
        w_next = S_STOP;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    case (bus.icode)
      IC_CALL: w_pc_next = bus.valC;
      IC_JXX:  w_pc_next = r_cnd ? bus.valC : bus.valP;
      IC_RET:  w_pc_next = bus.valM;
      default: w_pc_next = bus.valP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_stat  <= ST_AOK;
      r_cnd   <= 1'b0;
      r_count <= 32'd0;
    end else begin
      if (r_state == S_EXECUTE) r_cnd <= bus.cnd;
      if (w_stop_load)          r_stat <= w_stop_code;
      if (r_state == S_PCUPD) begin
        r_pc    <= w_pc_next;
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign bus.PC          = r_pc;
  assign bus.stage_en    = w_stage_en;
  assign bus.stat        = (r_state == S_STOP) ? r_stat : ST_AOK;
  assign bus.retire      = (r_state == S_PCUPD);
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: stage walk, next-PC selection, faults, stepping and reset abort.
module tb_seq_ctrl;
  localparam logic [63:0] RPC = 64'h1000;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  seq_ctrl_if u_if ();

  seq_ctrl #(.RESET_PC(RPC), .HALT_ICODE(4'h0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Runs one instruction from FETCH through the PCUPD edge; cnd is only correct during EXECUTE.
  task automatic do_instr(input string tag, input logic cnd_val);
    for (int i = 0; i < 6; i++) begin
      u_if.cnd = (i == 2) ? cnd_val : ~cnd_val;
      chk({tag, "_stage_en"}, {58'd0, u_if.stage_en}, 64'd1 << i);
      chk({tag, "_retire"}, {63'd0, u_if.retire}, (i == 5) ? 64'd1 : 64'd0);
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    u_if.start = 0; u_if.step_mode = 0; u_if.step = 0;
    u_if.icode = 4'h1; u_if.instr_valid = 1; u_if.imem_error = 0; u_if.dmem_error = 0;
    u_if.cnd = 0; u_if.valC = 64'h0; u_if.valP = 64'h0; u_if.valM = 64'h0;
    tick();
    tick();

    chk("rst_pc", u_if.PC, RPC);
    chk("rst_stage_en", {58'd0, u_if.stage_en}, 64'd0);
    chk("rst_stat", {61'd0, u_if.stat}, 64'd1);
    chk("rst_retire", {63'd0, u_if.retire}, 64'd0);
    chk("rst_count", {32'd0, u_if.instr_count}, 64'd0);

    reset = 1'b0;
    tick();
    tick();
    chk("idle_stage_en", {58'd0, u_if.stage_en}, 64'd0);

    // nop
    u_if.icode = 4'h1; u_if.valP = 64'h2; u_if.start = 1;
    tick();
    u_if.start = 0;
    do_instr("nop", 1'b0);
    chk("nop_pc", u_if.PC, 64'h2);
    chk("nop_count", {32'd0, u_if.instr_count}, 64'd1);

    // jxx not taken, then taken
    u_if.icode = 4'h7; u_if.valC = 64'h40; u_if.valP = 64'h09;
    do_instr("jxx0", 1'b0);
    chk("jxx0_pc", u_if.PC, 64'h09);
    do_instr("jxx1", 1'b1);
    chk("jxx1_pc", u_if.PC, 64'h40);

    // call, ret
    u_if.icode = 4'h8; u_if.valC = 64'h100; u_if.valP = 64'h55; u_if.valM = 64'h77;
    do_instr("call", 1'b0);
    chk("call_pc", u_if.PC, 64'h100);
    u_if.icode = 4'h9; u_if.valM = 64'h0A;
    do_instr("ret", 1'b1);
    chk("ret_pc", u_if.PC, 64'h0A);
    chk("ret_count", {32'd0, u_if.instr_count}, 64'd5);

    // single-step, then reset during EXECUTE
    u_if.step_mode = 1; u_if.icode = 4'h1; u_if.valP = 64'h20;
    do_instr("stp", 1'b0);
    chk("stp_pc", u_if.PC, 64'h20);
    for (int i = 0; i < 3; i++) begin
      chk("pause_stage_en", {58'd0, u_if.stage_en}, 64'd0);
      chk("pause_retire", {63'd0, u_if.retire}, 64'd0);
      tick();
    end
    u_if.step = 1;
    tick();
    u_if.step = 0;
    chk("step_fetch", {58'd0, u_if.stage_en}, 64'h01);
    tick();
    tick();
    chk("at_execute", {58'd0, u_if.stage_en}, 64'h04);
    reset = 1'b1;
    #1;
    chk("async_pc", u_if.PC, RPC);
    chk("async_count", {32'd0, u_if.instr_count}, 64'd0);
    chk("async_stage_en", {58'd0, u_if.stage_en}, 64'd0);
    tick();
    reset = 1'b0;
    u_if.step_mode = 0;
    tick();
    tick();
    chk("post_rst_idle", {58'd0, u_if.stage_en}, 64'd0);
    chk("post_rst_retire", {63'd0, u_if.retire}, 64'd0);

    // halt
    u_if.icode = 4'h0; u_if.start = 1;
    tick();
    u_if.start = 0;
    chk("halt_fetch", {58'd0, u_if.stage_en}, 64'h01);
    tick();
    chk("halt_stat", {61'd0, u_if.stat}, 64'd2);
    chk("halt_stage_en", {58'd0, u_if.stage_en}, 64'd0);
    chk("halt_pc", u_if.PC, RPC);
    u_if.start = 1; u_if.step = 1;
    tick();
    tick();
    u_if.start = 0; u_if.step = 0;
    chk("stop_hold_stat", {61'd0, u_if.stat}, 64'd2);
    chk("stop_hold_stage_en", {58'd0, u_if.stage_en}, 64'd0);
    do_reset();
    chk("halt_rst_stat", {61'd0, u_if.stat}, 64'd1);
    chk("halt_rst_idle", {58'd0, u_if.stage_en}, 64'd0);

    // imem_error beats !instr_valid
    u_if.icode = 4'h1; u_if.imem_error = 1; u_if.instr_valid = 0; u_if.start = 1;
    tick();
    u_if.start = 0;
    tick();
    chk("imem_stat", {61'd0, u_if.stat}, 64'd3);
    u_if.imem_error = 0;
    do_reset();

    // illegal instruction
    u_if.start = 1;
    tick();
    u_if.start = 0;
    tick();
    chk("ins_stat", {61'd0, u_if.stat}, 64'd4);
    u_if.instr_valid = 1;
    do_reset();

    // dmem_error in MEMORY
    u_if.icode = 4'h1; u_if.valP = 64'h33; u_if.start = 1;
    tick();
    u_if.start = 0;
    tick();
    tick();
    tick();
    chk("at_memory", {58'd0, u_if.stage_en}, 64'h08);
    chk("mem_stat_aok", {61'd0, u_if.stat}, 64'd1);
    u_if.dmem_error = 1;
    tick();
    u_if.dmem_error = 0;
    chk("dmem_stat", {61'd0, u_if.stat}, 64'd3);
    chk("dmem_stage_en", {58'd0, u_if.stage_en}, 64'd0);
    chk("dmem_retire", {63'd0, u_if.retire}, 64'd0);
    tick();
    chk("dmem_no_wb", {58'd0, u_if.stage_en}, 64'd0);
    chk("dmem_pc", u_if.PC, RPC);
    chk("dmem_count", {32'd0, u_if.instr_count}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
